// File: rtl/wave_sample_scheduler_if.sv
// Scheduler-side bundle: config inputs, generator strobes/samples and the output byte stream.
// master = scheduler, slave = the generators/host/downstream sink.
interface wave_sample_scheduler_if #(
  parameter int N_SRC = 4,
  parameter int DIV_W = 16
);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic                 enable;
  logic                 cfg_load;
  logic [DIV_W-1:0]     cfg_div;
  logic [SEL_W-1:0]     cfg_sel;
  logic [N_SRC-1:0]     gen_valid;
  logic [8*N_SRC-1:0]   gen_data;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_ready;
  logic [7:0]           overrun_cnt;
  logic                 busy;

  modport master (
    input  enable, cfg_load, cfg_div, cfg_sel, gen_data, out_ready,
    output gen_valid, out_valid, out_data, overrun_cnt, busy
  );

  modport slave (
    output enable, cfg_load, cfg_div, cfg_sel, gen_data, out_ready,
    input  gen_valid, out_valid, out_data, overrun_cnt, busy
  );
endinterface

// File: rtl/wave_sample_scheduler.sv
// Strobes one selected generator every div+1 cycles, captures its sample the next cycle into a
// small FIFO (out_valid two cycles after the strobe); a full FIFO without a pop drops the sample.
module wave_sample_scheduler #(
  parameter int N_SRC      = 4,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  wave_sample_scheduler_if.master bus
);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  sh_div;
  logic [DIV_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  sh_sel;
  logic              cfg_pend;
  logic              cap_pend;
  logic [N_SRC-1:0]  gen_valid_q;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        overrun_q;

  logic              at_tick;
  logic              apply_cfg;
  logic [DIV_W-1:0]  div_new;
  logic [SEL_W-1:0]  sel_new;
  logic [SEL_W-1:0]  load_sel;
  logic [7:0]        cap_data;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = N_SRC'(1) << s;
  endfunction

  // at_tick is exactly the cycle in which gen_valid_q is high
  assign at_tick   = (state == RUN) && (cnt == div);
  assign apply_cfg = ((state == IDLE) && cfg_pend) || (state == SWITCH);
  assign div_new   = cfg_pend ? sh_div : div;
  assign sel_new   = cfg_pend ? sh_sel : sel;

  always_comb begin
    load_sel = bus.cfg_sel;
    if (int'(bus.cfg_sel) >= N_SRC)
      load_sel = SEL_W'(N_SRC - 1);
  end

  // sel only changes at the end of the capture cycle, so it still names the strobed source
  assign cap_data = bus.gen_data[8*int'(sel) +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div         <= '0;
      sh_div      <= '0;
      cnt         <= '0;
      sel         <= '0;
      sh_sel      <= '0;
      cfg_pend    <= 1'b0;
      cap_pend    <= 1'b0;
      gen_valid_q <= '0;
    end else begin
      cap_pend <= at_tick;

      if (bus.cfg_load) begin
        sh_div <= bus.cfg_div;
        sh_sel <= load_sel;
      end

      if (bus.cfg_load)
        cfg_pend <= 1'b1;
      else if (apply_cfg)
        cfg_pend <= 1'b0;

      // gen_valid_q is loaded with the strobe that the next-cycle state/cnt/div will produce
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cfg_pend) begin
            div <= sh_div;
            sel <= sh_sel;
          end
          if (bus.enable) begin
            state       <= RUN;
            gen_valid_q <= (div_new == '0) ? onehot(sel_new) : '0;
          end else begin
            gen_valid_q <= '0;
          end
        end

        RUN: begin
          if (!bus.enable) begin
            state       <= IDLE;
            cnt         <= '0;
            gen_valid_q <= '0;
          end else if (cnt == div) begin
            cnt <= '0;
            if (cfg_pend) begin
              state       <= SWITCH;
              gen_valid_q <= '0;
            end else begin
              gen_valid_q <= (div == '0) ? onehot(sel) : '0;
            end
          end else begin
            cnt         <= cnt + DIV_W'(1);
            gen_valid_q <= ((cnt + DIV_W'(1)) == div) ? onehot(sel) : '0;
          end
        end

        SWITCH: begin
          div <= sh_div;
          sel <= sh_sel;
          cnt <= '0;
          if (bus.enable) begin
            state       <= RUN;
            gen_valid_q <= (sh_div == '0) ? onehot(sh_sel) : '0;
          end else begin
            state       <= IDLE;
            gen_valid_q <= '0;
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= '0;
          gen_valid_q <= '0;
        end
      endcase
    end
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = (count != '0) && bus.out_ready;
  assign push_ok = cap_pend && (!full || pop);
  assign drop    = cap_pend && !push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overrun_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= cap_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (drop && (overrun_q != 8'hFF))
        overrun_q <= overrun_q + 8'd1;
    end
  end

  assign bus.gen_valid   = gen_valid_q;
  assign bus.out_valid   = (count != '0);
  assign bus.out_data    = mem[rd_ptr];
  assign bus.overrun_cnt = overrun_q;
  assign bus.busy        = (state != IDLE) || (count != '0);

endmodule

// File: doc/wave_sample_scheduler.md
# wave_sample_scheduler

Sample-rate scheduler and source arbiter for the LUT waveform generators. Issues one-cycle `in_valid` strobes to exactly one selected generator at a programmable divided rate from the 50 MHz clock, captures that generator's 8-bit sample, and queues it in a small FIFO feeding a valid/ready byte stream toward the UART TX / DAC path. It also applies source and rate changes glitch-free, at sample boundaries.

## Interface
- `N_SRC`, 4: number of generator sources; index width `SEL_W = $clog2(N_SRC)`, minimum 1.
- `DIV_W`, 16: width of the rate divider.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two, at least 2.

- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 1 = run the scheduler.
- `cfg_load`  in  1  pulse; captures `cfg_div` and `cfg_sel` into the shadow registers.
- `cfg_div`  in  DIV_W  sample period minus one, in clk cycles.
- `cfg_sel`  in  SEL_W  source index. Values ≥ N_SRC are clamped to N_SRC-1.
- `gen_valid`  out  N_SRC  one-hot sample strobes to the generators' `in_valid`.
- `gen_data`  in  8*N_SRC  generator outputs; source i occupies bits [8i+7:8i].
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  8  FIFO head sample.
- `out_ready`  in  1  downstream accept.
- `overrun_cnt`  out  8  count of dropped samples; saturates at 255.
- `busy`  out  1  1 when state ≠ IDLE or the FIFO is non-empty.

## Operation
- Registers:
  - active `div`/`sel`
  - shadow `div`/`sel` plus a `cfg_pend` flag
  - tick counter `cnt`
  - capture flag `cap_pend`
  - FIFO with read pointer, write pointer and occupancy count
- FSM states are IDLE, RUN, SWITCH.
  - IDLE:
    - `cnt` is held at 0.
    - If `cfg_pend` is set, the shadow values are copied to active and `cfg_pend` clears.
    - `enable`=1 moves to RUN.
  - RUN:
    - `cnt` increments each cycle.
    - When `cnt == div`, `gen_valid[sel]` is pulsed for one cycle and `cnt` returns to 0.
    - `cnt` is compared at full DIV_W width, so `div` = 0 gives a strobe every cycle.
    - If `cfg_pend`=1 on a strobe cycle, move to SWITCH after that strobe.
    - If `enable`=0, move to IDLE immediately. No further strobes are issued, and a pending capture still completes.
  - SWITCH:
    - Lasts one cycle and completes the pending capture from the old `sel`.
    - Copies shadow to active, clears `cfg_pend`, sets `cnt` to 0.
    - Returns to RUN, or to IDLE if `enable`=0.
- `cfg_load`:
  - Overwrites the shadow registers and sets `cfg_pend`.
  - Repeated loads before application: the last one wins.
  - A load in the same cycle as application is kept pending for the next boundary.
- Capture:
  - The cycle after a strobe, `gen_data[old sel]` is pushed into the FIFO. The generator LUT output settles one edge after its `in_valid`.
  - The push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `overrun_cnt` increments, saturating.
- FIFO:
  - Pop happens when `out_valid && out_ready`.
  - `out_data` is the registered head value. It is stable while `out_valid`=1 and `out_ready`=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves the occupancy count unchanged.

## Timing
- Reset values:
  - `gen_valid` = 0, `out_valid` = 0, `out_data` = 0x00, `overrun_cnt` = 0, `busy` = 0
  - active and shadow `div`/`sel` = 0, `cfg_pend` = 0, `cap_pend` = 0
  - state = IDLE, FIFO empty
- Reset asserted mid-operation clears everything immediately and asynchronously. The FIFO contents are discarded.
- The first strobe comes `div`+1 cycles after entering RUN. The strobe period is `div`+1 cycles.
- Latency:
  - strobe at cycle T
  - FIFO write at the end of T+1
  - `out_valid`=1 at T+2, provided the FIFO was empty
- A source switch has no gap beyond the period. The first strobe on the new `sel` comes new `div`+2 cycles after the last old strobe (one SWITCH cycle, then the new period).
- `gen_valid` is never multi-hot and never asserted outside RUN.

## Test plan
- **Basic rate:** reset, `cfg_div`=4, `cfg_sel`=1, load, `enable`=1, `out_ready`=1 → `gen_valid`=4'b0010 every 5 cycles. `out_data` tracks `gen_data[15:8]` two cycles after each strobe. `overrun_cnt`=0.
- **Backpressure/overrun:** `div`=0, `out_ready`=0 for 10 cycles, FIFO_DEPTH=4 → `out_valid`=1 and the FIFO holds 4 samples. `overrun_cnt` reaches 5 or 6 depending on the capture alignment checked in the bench. It saturates at 255 after 300 cycles. Releasing `out_ready` drains the 4 samples in order.
- **Switch at boundary:** run `sel`=0, `div`=9; `cfg_load` with `sel`=2, `div`=2 mid-period → remaining sel-0 strobes finish, one SWITCH cycle follows, then `gen_valid`=4'b0100 every 3 cycles. No cycle has two strobe bits set.
- **Clamp and last-wins:** two `cfg_load`s with `sel`=7 then `sel`=3, N_SRC=4 → only `gen_valid[3]` strobes.
- **Enable drop / reset mid-run:**
  - `enable`=0 the cycle after a strobe → that sample is still captured, then no strobes follow and `busy` falls once the FIFO is empty.
  - `rst_n`=0 with 3 samples queued → `out_valid`=0 and `overrun_cnt`=0 immediately.
- **Full push+pop:** FIFO full with `out_ready`=1 on a capture cycle → sample accepted, occupancy stays 4, `overrun_cnt` unchanged.
